// File: rtl/ysyx_ifu_resp.sv
// Instruction-fetch responder: word-addressed instruction RAM with fixed access latency
// and optional two-beat (even word, odd word) line fills inside a configurable address window.
module ysyx_ifu_resp #(
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] MEM_BASE  = 'h80000000,
  parameter int unsigned       MEM_WORDS = 4096,
  parameter int unsigned       LATENCY   = 2,
  parameter int unsigned       BEAT_GAP  = 1,
  parameter bit                BURST_EN  = 1'b1,
  parameter logic [DATA_W-1:0] BURST_LO  = 'ha0000000,
  parameter logic [DATA_W-1:0] BURST_HI  = 'hc0000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  input  logic              ifu_required,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_rvalid,
  output logic              ifu_rerr,
  input  logic              ld_we,
  input  logic [DATA_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata
);

  localparam int IW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(LATENCY + 1);
  localparam int GW = (BEAT_GAP > 0) ? $clog2(BEAT_GAP + 1) : 1;
  localparam logic [DATA_W:0]   MEM_END  = {1'b0, MEM_BASE} + (DATA_W+1)'(4 * MEM_WORDS);
  localparam logic [DATA_W-1:0] LINE_OFS = DATA_W'(4);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_BEAT0, S_GAP, S_BEAT1} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] addr_q;
  logic              burst_q;
  logic [CW-1:0]     lat_cnt_q;
  logic [GW-1:0]     gap_cnt_q;
  logic              rvalid_q;
  logic              rerr_q;
  logic [DATA_W-1:0] mem_rd_q;

  logic [DATA_W-1:0] mem [MEM_WORDS];

  logic [DATA_W-1:0] beat_addr;
  logic [DATA_W-1:0] rd_off;
  logic [DATA_W-1:0] ld_off;
  logic [IW-1:0]     rd_idx;
  logic [IW-1:0]     ld_idx;
  logic              rd_ok;
  logic              ld_ok;
  logic              abandon;
  logic              req_burst;
  logic              unused_bits;

  // Address of the word the next beat returns; only meaningful in BEAT0/BEAT1.
  always_comb begin
    beat_addr = addr_q;
    if (state_q == S_BEAT1) begin
      beat_addr = addr_q | LINE_OFS;
    end else if (burst_q) begin
      beat_addr = addr_q & ~LINE_OFS;
    end
  end

  assign rd_off    = beat_addr - MEM_BASE;
  assign ld_off    = ld_addr - MEM_BASE;
  assign rd_idx    = rd_off[IW+1:2];
  assign ld_idx    = ld_off[IW+1:2];
  assign rd_ok     = ({1'b0, beat_addr} >= {1'b0, MEM_BASE}) && ({1'b0, beat_addr} < MEM_END);
  assign ld_ok     = ({1'b0, ld_addr} >= {1'b0, MEM_BASE}) && ({1'b0, ld_addr} < MEM_END);
  assign abandon   = !ifu_required && !ifu_arvalid;
  assign req_burst = BURST_EN && (ifu_araddr >= BURST_LO) && (ifu_araddr <= BURST_HI);

  assign unused_bits = ^{rd_off[1:0], rd_off[DATA_W-1:IW+2], ld_off[1:0], ld_off[DATA_W-1:IW+2]};

  // Write-before-read ordering is not used: a beat reading the word being preloaded sees old data.
  always_ff @(posedge clk) begin
    if (ld_we && ld_ok) begin
      mem[ld_idx] <= ld_wdata;
    end
    mem_rd_q <= mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      burst_q   <= 1'b0;
      lat_cnt_q <= '0;
      gap_cnt_q <= '0;
      rvalid_q  <= 1'b0;
      rerr_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // The cycle right after a beat never accepts, so a held arvalid is not re-served.
          if (ifu_arvalid && !rvalid_q) begin
            addr_q    <= ifu_araddr;
            burst_q   <= req_burst;
            lat_cnt_q <= CW'(LATENCY - 1);
            state_q   <= (LATENCY == 1) ? S_BEAT0 : S_WAIT;
          end
        end
        S_WAIT: begin
          if (abandon) begin
            state_q <= S_IDLE;
          end else begin
            lat_cnt_q <= lat_cnt_q - CW'(1);
            if (lat_cnt_q == CW'(1)) begin
              state_q <= S_BEAT0;
            end
          end
        end
        S_BEAT0: begin
          rvalid_q <= 1'b1;
          rerr_q   <= !rd_ok;
          if (burst_q) begin
            gap_cnt_q <= GW'(BEAT_GAP);
            state_q   <= (BEAT_GAP == 0) ? S_BEAT1 : S_GAP;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_GAP: begin
          if (abandon) begin
            state_q <= S_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q - GW'(1);
            if (gap_cnt_q == GW'(1)) begin
              state_q <= S_BEAT1;
            end
          end
        end
        S_BEAT1: begin
          rvalid_q <= 1'b1;
          rerr_q   <= !rd_ok;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ifu_rvalid = rvalid_q;
  assign ifu_rerr   = rerr_q;
  assign ifu_rdata  = (rvalid_q && !rerr_q) ? mem_rd_q : '0;

endmodule

// File: tb/tb_ysyx_ifu_resp.sv
// Directed bench for ysyx_ifu_resp: latency, holds, bursts, range errors, abandon, reset and preload.
module tb_ysyx_ifu_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ifu_araddr;
  logic        ifu_arvalid;
  logic        ifu_required;
  logic [31:0] ifu_rdata;
  logic        ifu_rvalid;
  logic        ifu_rerr;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;

  int n_checks = 0;
  int n_pass   = 0;
  int rv_count = 0;

  ysyx_ifu_resp #(
    .DATA_W   (32),
    .MEM_BASE (32'h8000_0000),
    .MEM_WORDS(4096),
    .LATENCY  (2),
    .BEAT_GAP (1),
    .BURST_EN (1'b1),
    .BURST_LO (32'h8000_2000),
    .BURST_HI (32'h8000_2fff)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ifu_araddr  (ifu_araddr),
    .ifu_arvalid (ifu_arvalid),
    .ifu_required(ifu_required),
    .ifu_rdata   (ifu_rdata),
    .ifu_rvalid  (ifu_rvalid),
    .ifu_rerr    (ifu_rerr),
    .ld_we       (ld_we),
    .ld_addr     (ld_addr),
    .ld_wdata    (ld_wdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ifu_rvalid) rv_count <= rv_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-14s got=%08h", tag, got);
    end else begin
      $display("FAIL %-14s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    ld_we = 1'b1; ld_addr = a; ld_wdata = d;
    step();
    ld_we = 1'b0;
  endtask

  // One non-burst request; lat counts cycles from the accept edge to the rvalid cycle.
  task automatic fetch(input logic [31:0] a, input bit hold,
                       output logic [31:0] d, output logic e, output int lat);
    ifu_araddr = a; ifu_arvalid = 1'b1; ifu_required = 1'b1;
    d = '0; e = 1'b0; lat = 0;
    step();
    if (!hold) ifu_arvalid = 1'b0;
    while (!ifu_rvalid && lat < 20) begin
      step();
      lat++;
    end
    d = ifu_rdata;
    e = ifu_rerr;
    step();
    ifu_arvalid = 1'b0;
  endtask

  logic [31:0] d;
  logic        e;
  int          lat;
  int          rv0;

  initial begin
    rst = 1'b0; ifu_araddr = '0; ifu_arvalid = 1'b0; ifu_required = 1'b1;
    ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
    step(); step();
    check("rst rvalid", {31'b0, ifu_rvalid}, 32'd0);
    check("rst rerr",   {31'b0, ifu_rerr},   32'd0);
    check("rst rdata",  ifu_rdata,           32'd0);
    rst = 1'b1;

    preload(32'h8000_0000, 32'h0000_0413);
    preload(32'h8000_0008, 32'h1111_1111);
    preload(32'h8000_000c, 32'h2222_2222);
    preload(32'h8000_2000, 32'haaaa_0000);
    preload(32'h8000_2004, 32'hbbbb_0001);
    preload(32'h8000_3ffc, 32'hcccc_3ffc);
    step();

    // T1: exact timing of a single request
    ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1;
    step();
    ifu_arvalid = 1'b0;
    check("T1 rv@T",   {31'b0, ifu_rvalid}, 32'd0);
    step();
    check("T1 rv@T+1", {31'b0, ifu_rvalid}, 32'd0);
    step();
    check("T1 rv@T+2", {31'b0, ifu_rvalid}, 32'd1);
    check("T1 rdata",  ifu_rdata,           32'h0000_0413);
    check("T1 rerr",   {31'b0, ifu_rerr},   32'd0);
    step();
    check("T1 rv@T+3", {31'b0, ifu_rvalid}, 32'd0);
    check("T1 rdata0", ifu_rdata,           32'd0);
    step();

    // T2: two requests with arvalid held through each beat cycle
    rv0 = rv_count;
    fetch(32'h8000_0008, 1'b1, d, e, lat);
    check("T2 lat0",  lat, 32'd2);
    check("T2 word2", d,   32'h1111_1111);
    fetch(32'h8000_000c, 1'b1, d, e, lat);
    check("T2 lat1",  lat, 32'd2);
    check("T2 word3", d,   32'h2222_2222);
    repeat (5) step();
    check("T2 pulses", rv_count - rv0, 32'd2);

    // T3: burst line fill from the odd word address
    rv0 = rv_count;
    ifu_araddr = 32'h8000_2004; ifu_arvalid = 1'b1;
    step();
    ifu_arvalid = 1'b0;
    step();
    check("T3 rv@T+1", {31'b0, ifu_rvalid}, 32'd0);
    step();
    check("T3 rv@T+2", {31'b0, ifu_rvalid}, 32'd1);
    check("T3 beat0",  ifu_rdata,           32'haaaa_0000);
    step();
    check("T3 rv@T+3", {31'b0, ifu_rvalid}, 32'd0);
    step();
    check("T3 rv@T+4", {31'b0, ifu_rvalid}, 32'd1);
    check("T3 beat1",  ifu_rdata,           32'hbbbb_0001);
    step(); step(); step();
    check("T3 pulses", rv_count - rv0, 32'd2);

    // T4: range boundaries
    fetch(32'h7fff_fffc, 1'b0, d, e, lat);
    check("T4 lo lat",  lat, 32'd2);
    check("T4 lo rerr", {31'b0, e}, 32'd1);
    check("T4 lo data", d, 32'd0);
    fetch(32'h8000_3ffe, 1'b0, d, e, lat);
    check("T4 top rerr", {31'b0, e}, 32'd0);
    check("T4 top data", d, 32'hcccc_3ffc);
    fetch(32'h8000_4000, 1'b0, d, e, lat);
    check("T4 hi rerr", {31'b0, e}, 32'd1);
    check("T4 hi data", d, 32'd0);

    // T5: abandon in WAIT, then normal service
    rv0 = rv_count;
    ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1;
    step();
    ifu_arvalid = 1'b0; ifu_required = 1'b0;
    step();
    ifu_required = 1'b1;
    repeat (10) step();
    check("T5 no rv", rv_count - rv0, 32'd0);
    fetch(32'h8000_0008, 1'b0, d, e, lat);
    check("T5 lat",  lat, 32'd2);
    check("T5 data", d,   32'h1111_1111);

    // Abandon in GAP: beat0 only
    rv0 = rv_count;
    ifu_araddr = 32'h8000_2000; ifu_arvalid = 1'b1;
    step();
    ifu_arvalid = 1'b0;
    step(); step();
    ifu_required = 1'b0;
    step();
    ifu_required = 1'b1;
    repeat (5) step();
    check("GAP abandon", rv_count - rv0, 32'd1);

    // T6: reset during GAP drops beat1 and keeps memory
    rv0 = rv_count;
    ifu_araddr = 32'h8000_2000; ifu_arvalid = 1'b1;
    step();
    ifu_arvalid = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    check("T6 rvalid", {31'b0, ifu_rvalid}, 32'd0);
    check("T6 rerr",   {31'b0, ifu_rerr},   32'd0);
    check("T6 rdata",  ifu_rdata,           32'd0);
    rst = 1'b1;
    repeat (5) step();
    check("T6 pulses", rv_count - rv0, 32'd1);
    fetch(32'h8000_0000, 1'b0, d, e, lat);
    check("T6 kept", d, 32'h0000_0413);

    // Preload colliding with the beat read returns old data, later reads see the new word
    ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1;
    step();
    ifu_arvalid = 1'b0;
    step();
    ld_we = 1'b1; ld_addr = 32'h8000_0000; ld_wdata = 32'h0000_0099;
    step();
    ld_we = 1'b0;
    check("WR old rv",   {31'b0, ifu_rvalid}, 32'd1);
    check("WR old data", ifu_rdata, 32'h0000_0413);
    step();
    fetch(32'h8000_0000, 1'b0, d, e, lat);
    check("WR new data", d, 32'h0000_0099);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
